bisect_arbiter: RTL
===================

Name: bisect_arbiter

Overview:
- Shares one bisection root-finder unit between two requesters: client 0 and client 1.
- The unit solves x^2 - b*x - c = 0 on [l_0, r_0] and uses the soc/eoc handshake.
- Round-robin grant; operands are latched per job and the result is returned with the same handshake.
- A watchdog resets the unit and reports an error if a job hangs (e.g. degenerate interval l_0 == r_0).

Parameters:
- MAX_CYCLES, 64: cycles allowed from grant to unit eoc rising before abort.
- CW, 8: watchdog counter width; must satisfy 2^CW > MAX_CYCLES.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- soc0, soc1  in  1  start-of-conversion from client k.
- eoc0, eoc1  out  1  end-of-conversion to client k.
- b0, b1  in  10  coefficient b from client k.
- c0, c1  in  10  coefficient c from client k.
- l0_0, l0_1  in  8  interval left end from client k.
- r0_0, r0_1  in  8  interval right end from client k.
- x0_0, x0_1  out  8  root result to client k, held until that client's next job completes.
- err0, err1  out  1  1 = last job of client k aborted by watchdog.
- u_b  out  10  registered operand b to the unit.
- u_c  out  10  registered operand c to the unit.
- u_l0, u_r0  out  8  registered interval ends to the unit.
- u_soc  out  1  start-of-conversion to the unit.
- u_eoc  in  1  end-of-conversion from the unit.
- u_x0  in  8  result from the unit.
- u_rst_  out  1  active-low reset to the unit.

Behaviour:
- Client protocol, per client k:
  - Client raises sock while eock=1.
  - Arbiter drops eock when it grants the job.
  - Client drops sock.
  - Arbiter raises eock with x0_k/errk valid, never before sock is seen at 0.
- Reset (reset=1 at clock edge):
  - State IDLE; eoc0=eoc1=1; x0_0=x0_1=0; err0=err1=0; u_soc=0; u_rst_=0; last=1; cnt=0.
  - u_* operand registers reset to 0.
- First edge after reset deasserts: u_rst_<=1. The unit is therefore held in reset throughout arbiter reset, including reset asserted mid-job; a job in flight is dropped without reporting.
- States: IDLE, LAUNCH, RUN, ABORT, WAITC. The granted client index g is registered.
- IDLE:
  - reqk = sock & eock.
  - If both request: g = client != last. Otherwise g = the single requester.
  - On grant: latch that client's b/c/l0/r0 into u_*, eocg<=0, cnt<=0, go LAUNCH.
  - No request: stay IDLE.
- LAUNCH:
  - u_soc<=1, cnt<=cnt+1.
  - When u_eoc==0: u_soc<=0, go RUN.
- RUN:
  - cnt<=cnt+1.
  - When u_eoc==1: x0_g<=u_x0, errg<=0, go WAITC.
- Watchdog:
  - In LAUNCH or RUN, when cnt==MAX_CYCLES-1 and the exit condition is false: u_soc<=0, u_rst_<=0, cnt<=0, go ABORT.
  - Watchdog has priority over nothing: if the normal exit condition is true in the same cycle, the normal exit wins.
- ABORT:
  - Hold u_rst_=0 for exactly 2 cycles.
  - Then u_rst_<=1, x0_g<=0, errg<=1, go WAITC.
- WAITC:
  - When socg==0: eocg<=1, last<=g, go IDLE.
  - The other client's request stays pending (its eoc stays 1) and is served next.
- Latency:
  - Grant occurs 1 cycle after soc is sampled in IDLE.
  - eocg rises 1 cycle after socg==0 is sampled in WAITC.
  - Minimum round trip is unit latency + 3 cycles.
- Client dropping soc before being granted: no request; nothing happens.
- Client operands may change after grant without effect.
- The non-granted client's outputs never change during another client's job.

Test Plan:
- Client 0, b=10 c=24 l0=0 r0=255 -> eoc0 falls 1 cycle after grant; after soc0 drops, eoc0=1, x0_0=12, err0=0; client 1 outputs untouched.
- Client 1, b=0 c=100 l0=0 r0=255 -> x0_1=10, err1=0; u_b/u_c/u_l0/u_r0 equal 0/100/0/255 from grant to job end.
- Both soc0=soc1=1 in the same cycle after reset -> client 0 served first (last=1), then client 1 with no idle gap beyond 1 IDLE cycle. Repeat with both requesting -> order alternates 0,1,0,1.
- Client 0 with l0=r0=50 (unit never terminates) -> u_rst_=0 for exactly 2 cycles starting MAX_CYCLES cycles after grant; then x0_0=0, err0=1. A following normal job from client 0 clears err0.
- reset=1 asserted while in RUN -> next cycle: eoc0=eoc1=1, u_soc=0, u_rst_=0. After release, u_rst_=1 one cycle later and a new request completes correctly.
- Client holds soc0=1 for 20 cycles after eoc0 falls -> eoc0 stays 0 until 1 cycle after soc0 drops, even though the unit has finished.

Source files
------------

// File: rtl/bisect_arbiter.sv
// Purpose: round-robin share of one bisection root-finder between two soc/eoc clients, with a hang watchdog.
// Latency: grant 1 cycle after soc sampled in IDLE; eoc back 1 cycle after soc seen low; round trip >= unit latency + 3.
// Backpressure: a pending client keeps soc high with eoc=1 until granted; a finished job waits in WAITC until its soc drops.
module bisect_arbiter #(
    parameter int MAX_CYCLES = 64,
    parameter int CW         = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        soc0,
    input  logic        soc1,
    output logic        eoc0,
    output logic        eoc1,
    input  logic [9:0]  b0,
    input  logic [9:0]  b1,
    input  logic [9:0]  c0,
    input  logic [9:0]  c1,
    input  logic [7:0]  l0_0,
    input  logic [7:0]  l0_1,
    input  logic [7:0]  r0_0,
    input  logic [7:0]  r0_1,
    output logic [7:0]  x0_0,
    output logic [7:0]  x0_1,
    output logic        err0,
    output logic        err1,
    output logic [9:0]  u_b,
    output logic [9:0]  u_c,
    output logic [7:0]  u_l0,
    output logic [7:0]  u_r0,
    output logic        u_soc,
    input  logic        u_eoc,
    input  logic [7:0]  u_x0,
    output logic        u_rst_
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        ABORT  = 3'd3,
        WAITC  = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state;
    state_t        state_nxt;
    logic          g;          // client owning the current job
    logic          last;       // client served most recently
    logic [CW-1:0] cnt;        // watchdog count in LAUNCH/RUN, hold count in ABORT

    logic          req0;
    logic          req1;
    logic          grant_sel;
    logic          soc_g;
    logic          cnt_last;

    logic          do_grant;
    logic          do_done;
    logic          do_abort;
    logic          abort_end;
    logic          do_release;

    // A request counts only while the client still sees eoc high; tie goes to the client not served last.
    always_comb begin
        req0      = soc0 & eoc0;
        req1      = soc1 & eoc1;
        grant_sel = (req0 & req1) ? ~last : req1;
        soc_g     = g ? soc1 : soc0;
        cnt_last  = (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a normal exit in the same cycle as the watchdog limit wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 | req1) state_nxt = LAUNCH;
            LAUNCH:  if (!u_eoc) state_nxt = RUN;
                     else if (cnt_last) state_nxt = ABORT;
            RUN:     if (u_eoc) state_nxt = WAITC;
                     else if (cnt_last) state_nxt = ABORT;
            ABORT:   if (cnt == CNT_ONE) state_nxt = WAITC;
            WAITC:   if (!soc_g) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output strobes decoded from state and handshake inputs.
    always_comb begin
        do_grant   = (state == IDLE) & (req0 | req1);
        do_done    = (state == RUN) & u_eoc;
        do_abort   = cnt_last & (((state == LAUNCH) & u_eoc) | ((state == RUN) & ~u_eoc));
        abort_end  = (state == ABORT) & (cnt == CNT_ONE);
        do_release = (state == WAITC) & ~soc_g;
    end

    // Registered datapath: operand latch, unit handshake, watchdog and per-client results.
    always_ff @(posedge clock) begin
        if (reset) begin
            g      <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
            eoc0   <= 1'b1;
            eoc1   <= 1'b1;
            x0_0   <= '0;
            x0_1   <= '0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            u_b    <= '0;
            u_c    <= '0;
            u_l0   <= '0;
            u_r0   <= '0;
            u_soc  <= 1'b0;
            u_rst_ <= 1'b0;
        end else begin
            // soc stays high through LAUNCH until the unit acknowledges by dropping eoc.
            u_soc  <= (state == LAUNCH) & u_eoc & ~do_abort;
            // Unit reset is held low for the abort cycle plus one more ABORT cycle.
            u_rst_ <= ~(do_abort | ((state == ABORT) & ~abort_end));

            if ((state == LAUNCH) || (state == RUN) || (state == ABORT)) begin
                cnt <= cnt + CNT_ONE;
            end
            if (do_abort) begin
                cnt <= '0;
            end

            if (do_grant) begin
                g    <= grant_sel;
                cnt  <= '0;
                u_b  <= grant_sel ? b1   : b0;
                u_c  <= grant_sel ? c1   : c0;
                u_l0 <= grant_sel ? l0_1 : l0_0;
                u_r0 <= grant_sel ? r0_1 : r0_0;
                if (grant_sel) eoc1 <= 1'b0;
                else           eoc0 <= 1'b0;
            end

            if (do_done) begin
                if (g) begin
                    x0_1 <= u_x0;
                    err1 <= 1'b0;
                end else begin
                    x0_0 <= u_x0;
                    err0 <= 1'b0;
                end
            end

            if (abort_end) begin
                if (g) begin
                    x0_1 <= '0;
                    err1 <= 1'b1;
                end else begin
                    x0_0 <= '0;
                    err0 <= 1'b1;
                end
            end

            if (do_release) begin
                last <= g;
                if (g) eoc1 <= 1'b1;
                else   eoc0 <= 1'b1;
            end
        end
    end

endmodule
